fpu_issue_ctrl: RTL
===================

Name: fpu_issue_ctrl

Overview:
Front-end and back-end controller for the 6-stage pipelined FPU, which has no stall or valid signalling.
- Accepts operation requests on a valid/ready interface and drives the FPU operand and operation inputs.
- Tracks in-flight operations with a tag shift pipeline and captures each FPU result at the correct cycle into a result FIFO.
- Returns tagged results on a valid/ready interface.
- Uses credit-based admission, so FPU results are never dropped even when the consumer back-pressures.

Parameters:
LATENCY, 6, clock edges from the fpu_* input registers changing to fpu_result holding that op's result (FPU input register plus 5 stage registers).
FIFO_DEPTH, 8, result FIFO entries and maximum outstanding ops (power of 2, ≥ 2).
TAG_W, 4, width of the request tag.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
in_operand1  input  32  IEEE-754 single, Op1.
in_operand2  input  32  IEEE-754 single, Op2.
in_operation  input  2  [1] 0 add/sub, 1 mul/div; [0] 0 add/mul, 1 sub/div.
in_tag  input  TAG_W  caller tag, returned with the result.
fpu_operand1  output  32  to FPU Operand1 (registered).
fpu_operand2  output  32  to FPU Operand2 (registered).
fpu_operation  output  2  to FPU Operation (registered).
fpu_result  input  32  from FPU Result.
out_valid  output  1  result available.
out_ready  input  1  consumer pops when out_valid && out_ready.
out_result  output  32  result word.
out_tag  output  TAG_W  tag of out_result.
out_flags  output  4  {nan, inf, zero, denorm}; exists only with FPU_ISSUE_FLAGS_EN.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RST).
- Reset values: fpu_operand1 = 0, fpu_operand2 = 0, fpu_operation = 0, tracking pipe all invalid, FIFO empty, credit count 0. Hence out_valid = 0 and out_result = out_tag = 0 (out_flags = 0).
- in_ready:
  - Equals 0 while RST = 1.
  - Otherwise equals (credit < FIFO_DEPTH).
  - Combinational from registers only; no path from in_valid.
- credit counter, width clog2(FIFO_DEPTH)+1:
  - +1 on accept; −1 on pop.
  - Accept and pop in the same cycle: unchanged.
  - Counts in-flight plus queued ops, so the FIFO can never overflow.
- Issue:
  - On accept, fpu_operand1/2/operation load in_operand1/2/in_operation at that edge.
  - With no accept, they hold their last value. The FPU keeps computing, but the result is ignored because the pipe entry is invalid.
  - Back-to-back accepts are allowed every cycle.
- Tracking pipe, stages 0..LATENCY of {valid, tag}:
  - Stage 0 loads {accept, in_tag} at each edge; every stage shifts each edge.
  - When stage LATENCY is valid, fpu_result holds that op's result. The FIFO writes {fpu_result, tag} at the next edge.
- Latency, empty FIFO: accept at edge k gives out_valid high after edge k+LATENCY+2 (8 cycles by default).
- Ordering: results are returned strictly in issue order.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Registered out_* show the head entry whenever out_valid = 1.
  - Simultaneous write and pop when full cannot occur (credit guarantees this). Simultaneous write and pop otherwise: count unchanged.
  - Pop from empty is ignored.
- Reset mid-operation: all in-flight and queued ops are discarded, with no out_valid afterwards. The FPU's internal pipeline keeps running, but its results are ignored because the pipe is cleared.
- Arithmetic: none on data; results pass through unmodified.

Optional Feature:
FPU_ISSUE_FLAGS_EN
- Defined:
  - Classify fpu_result as it is written into the FIFO:
    - nan = exp 0xFF and frac ≠ 0.
    - inf = exp 0xFF and frac = 0.
    - zero = exp 0 and frac = 0.
    - denorm = exp 0 and frac ≠ 0.
  - Store the 4 flag bits per FIFO entry and present them on out_flags.
- Undefined: no out_flags port and no flag storage.

Test Plan:
1. Single op: in_operand1 = 0x3F800000, in_operand2 = 0x40000000, in_operation = 00, tag = 3 → out_valid 8 cycles after accept, out_result = 0x40400000, out_tag = 3.
2. Mul: 0x40400000 × 0x40000000, in_operation = 10, tag = 5 → out_result = 0x40C00000, out_tag = 5; with FPU_ISSUE_FLAGS_EN, out_flags = 0000.
3. Streaming: 8 back-to-back accepts with tags 0..7 and out_ready = 1 → 8 consecutive out_valid cycles with tags 0..7 in order and correct sums.
4. Back-pressure: out_ready = 0, in_valid held high → exactly FIFO_DEPTH = 8 accepts, then in_ready = 0. Raise out_ready → one result per cycle, in_ready reasserts after the first pop, no result lost or duplicated.
5. Simultaneous accept and pop at credit = 8 → in_ready stays 0 that cycle; at credit = 7, accept and pop together leave credit at 7.
6. Reset with 3 ops in flight and 2 queued → out_valid = 0 after reset, no results for those tags, and a new op afterwards returns after 8 cycles.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue / retire controller wrapped around a fixed-latency pipelined FPU.
//   The FPU has no stall or valid signalling. This block does four things:
//   - It registers accepted requests onto the FPU operand and operation inputs.
//   - It follows each in-flight op with a {valid, tag} shift pipe.
//   - It captures fpu_result on the cycle that op's result is present.
//   - It queues results in a FIFO with a registered output stage.
//   Admission is credit based: every accepted op already owns a result slot,
//   so a back-pressuring consumer can never cause a result to be dropped.
//
// Optional build macro: FPU_ISSUE_FLAGS_EN
//   When defined, each captured result is classified as {nan, inf, zero,
//   denorm}. The class is stored alongside the result and driven on out_flags.
//   When undefined, the out_flags port and the flag storage do not exist.
//
// Ports
//   CLK, RST                           clock; synchronous active-high reset
//   in_valid / in_ready                request handshake
//   in_operand1/2, in_operation        request payload (operation: [1] mul/div, [0] sub/div)
//   in_tag                             caller tag, returned with the result
//   fpu_operand1/2, fpu_operation      registered drive into the FPU
//   fpu_result                         FPU result, LATENCY edges after its inputs change
//   out_valid / out_ready              result handshake
//   out_result, out_tag (out_flags)    registered head-of-queue result

module fpu_issue_ctrl #(
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_operand1,
  input  logic [31:0]      in_operand2,
  input  logic [1:0]       in_operation,
  input  logic [TAG_W-1:0] in_tag,

  output logic [31:0]      fpu_operand1,
  output logic [31:0]      fpu_operand2,
  output logic [1:0]       fpu_operation,
  input  logic [31:0]      fpu_result,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef FPU_ISSUE_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Handshakes and credit
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] credit;

  // in_ready depends only on registered credit (and RST), never on in_valid.
  assign in_ready = !RST && (credit < CNT_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Credit covers ops in the FPU, ops in the FIFO memory and the one held in
  // the output register. It is therefore an upper bound on FIFO occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      credit <= '0;
    end else if (accept && !pop) begin
      credit <= credit + CNT_W'(1);
    end else if (!accept && pop) begin
      credit <= credit - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Issue registers
  // ---------------------------------------------------------------------------
  // Without an accept these hold their value. The FPU keeps recomputing the
  // same op, but those results are never captured because no valid tag
  // travels with them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fpu_operand1  <= '0;
      fpu_operand2  <= '0;
      fpu_operation <= '0;
    end else if (accept) begin
      fpu_operand1  <= in_operand1;
      fpu_operand2  <= in_operand2;
      fpu_operation <= in_operation;
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking pipe
  // ---------------------------------------------------------------------------
  // Stage 0 loads alongside the issue registers. Stage LATENCY is therefore
  // valid exactly when fpu_result holds that op's result.
  logic [LATENCY:0] pipe_valid;
  logic [TAG_W-1:0] pipe_tag [0:LATENCY];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_valid <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_valid <= {pipe_valid[LATENCY-1:0], accept};
      pipe_tag[0] <= in_tag;
      for (int i = 1; i <= LATENCY; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result classification
  // ---------------------------------------------------------------------------
`ifdef FPU_ISSUE_FLAGS_EN
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic exp_ones;
    logic exp_zero;
    logic frac_zero;
    exp_ones  = (w[30:23] == 8'hFF);
    exp_zero  = (w[30:23] == 8'h00);
    frac_zero = (w[22:0] == 23'd0);
    return {exp_ones && !frac_zero,   // nan
            exp_ones &&  frac_zero,   // inf
            exp_zero &&  frac_zero,   // zero
            exp_zero && !frac_zero};  // denorm
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Result FIFO: circular memory plus a registered output stage
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic             load_out;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_count;
  logic [31:0]      mem_result [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag    [FIFO_DEPTH];
`ifdef FPU_ISSUE_FLAGS_EN
  logic [3:0]       mem_flags  [FIFO_DEPTH];
`endif

  assign wr_en = pipe_valid[LATENCY];

  // The output register is refilled from the memory whenever it is empty or
  // is being popped this cycle. This gives one result per cycle while the
  // consumer keeps popping.
  assign load_out = (mem_count != '0) && (!out_valid || pop);

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_result[wr_ptr] <= fpu_result;
      mem_tag[wr_ptr]    <= pipe_tag[LATENCY];
`ifdef FPU_ISSUE_FLAGS_EN
      mem_flags[wr_ptr]  <= classify(fpu_result);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load_out) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, load_out})
        2'b10:   mem_count <= mem_count + CNT_W'(1);
        2'b01:   mem_count <= mem_count - CNT_W'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
`ifdef FPU_ISSUE_FLAGS_EN
      out_flags  <= '0;
`endif
    end else if (load_out) begin
      out_valid  <= 1'b1;
      out_result <= mem_result[rd_ptr];
      out_tag    <= mem_tag[rd_ptr];
`ifdef FPU_ISSUE_FLAGS_EN
      out_flags  <= mem_flags[rd_ptr];
`endif
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule
